// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Voice-allocation scheduler between the MIDI byte parser and the per-voice
// envelope/oscillator engine. One note-on/note-off request is accepted at a
// time and the voice pool is then scanned one voice per clock. A note-on
// picks its target in this order:
//   retrigger same key > free voice > oldest released voice > oldest sounding
//   voice (steal).
// A note-off releases the lowest-index sounding voice that holds the key.
// Each resolved request produces one single-cycle event for the synth engine.
//
// Handshake: a request moves on a rising edge where req_valid and req_ready
// are both 1. req_ready is a register that is high only while the allocator
// is idle. The request fields are sampled on that edge, and the requester
// may change them on the next cycle.
//
// Ports
//   CLOCK_50     system clock, rising edge
//   reset_reg_N  asynchronous active-low reset
//   req_valid    request present
//   req_ready    allocator idle, request accepted on req_valid & req_ready
//   req_on       1 = note-on, 0 = note-off (a note-on with vel 0 is an off)
//   req_key      MIDI key 0..127
//   req_vel      velocity
//   all_off      one-cycle all-notes-off pulse, overrides everything
//   voice_free   per-voice "envelope finished" flags from the synth engine
//   keys_on      per-voice gate vector
//   active_keys  number of gates that are set
//   evt_valid    one-cycle event strobe
//   evt_on       1 = gate on, 0 = gate off
//   evt_voice    voice index of the event
//   evt_key      key of the event
//   evt_vel      velocity of the event
//   evt_steal    the note-on took over a voice that was still sounding
// ---------------------------------------------------------------------------
module voice_allocator #(
   parameter int VOICES  = 8,
   parameter int V_WIDTH = 3
) (
   input  logic               CLOCK_50,
   input  logic               reset_reg_N,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_on,
   input  logic [7:0]         req_key,
   input  logic [7:0]         req_vel,
   input  logic               all_off,
   input  logic [VOICES-1:0]  voice_free,
   output logic [VOICES-1:0]  keys_on,
   output logic [V_WIDTH:0]   active_keys,
   output logic               evt_valid,
   output logic               evt_on,
   output logic [V_WIDTH-1:0] evt_voice,
   output logic [7:0]         evt_key,
   output logic [7:0]         evt_vel,
   output logic               evt_steal
);

   localparam int                 AW       = V_WIDTH + 1;
   localparam logic [V_WIDTH-1:0] L_LAST   = V_WIDTH'(VOICES - 1);
   localparam logic [AW-1:0]      L_MAX    = AW'(VOICES);
   localparam logic [7:0]         L_NO_KEY = 8'hFF;
   localparam logic [7:0]         L_AGE_MX = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   // Note-on candidate classes, in priority order.
   typedef enum logic [1:0] {
      C_RETRIG = 2'd0,
      C_FREE   = 2'd1,
      C_REL    = 2'd2,
      C_STEAL  = 2'd3
   } cls_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t               r_state;
   logic                 r_req_ready;
   logic [V_WIDTH-1:0]   r_idx;

   logic                 r_on;
   logic [7:0]           r_req_key;
   logic [7:0]           r_req_vel;

   logic [VOICES-1:0]    r_vfree;
   logic [VOICES-1:0]    r_gate;
   logic [7:0]           r_key [VOICES];
   logic [7:0]           r_age [VOICES];
   logic [AW-1:0]        r_active;

   logic                 r_evt_valid;
   logic                 r_evt_on;
   logic [V_WIDTH-1:0]   r_evt_voice;
   logic [7:0]           r_evt_key;
   logic [7:0]           r_evt_vel;
   logic                 r_evt_steal;

   // Running best candidate of each class over the voices scanned so far.
   logic                 r_c0_found;
   logic [V_WIDTH-1:0]   r_c0_idx;
   logic                 r_c1_found;
   logic [V_WIDTH-1:0]   r_c1_idx;
   logic                 r_c2_found;
   logic [V_WIDTH-1:0]   r_c2_idx;
   logic [7:0]           r_c2_age;
   logic                 r_c3_found;
   logic [V_WIDTH-1:0]   r_c3_idx;
   logic [7:0]           r_c3_age;

   // ------------------------------------------------------------------
   // Wires
   // ------------------------------------------------------------------
   state_t               w_state_nxt;
   logic                 w_accept;
   logic                 w_last;

   logic                 w_cur_gate;
   logic                 w_cur_free;
   logic [7:0]           w_cur_key;
   logic [7:0]           w_cur_age;

   logic                 w_c0_found;
   logic [V_WIDTH-1:0]   w_c0_idx;
   logic                 w_c1_found;
   logic [V_WIDTH-1:0]   w_c1_idx;
   logic                 w_c2_found;
   logic [V_WIDTH-1:0]   w_c2_idx;
   logic [7:0]           w_c2_age;
   logic                 w_c3_found;
   logic [V_WIDTH-1:0]   w_c3_idx;
   logic [7:0]           w_c3_age;

   logic                 w_sel_found;
   logic [V_WIDTH-1:0]   w_sel_idx;
   cls_t                 w_sel_cls;

   assign w_accept = (r_state == S_IDLE) & r_req_ready & req_valid & ~all_off;
   assign w_last   = (r_idx == L_LAST);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state. all_off overrides every state.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_SCAN;
         S_SCAN:  if (w_last)   w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (all_off) begin
         w_state_nxt = S_IDLE;
      end
   end

   // ------------------------------------------------------------------
   // Scan step: fold the voice at r_idx into the running candidates.
   // Scanning runs in ascending index order, so "first seen" gives the
   // lowest index, and a strictly larger age is needed to displace an
   // earlier candidate. That breaks age ties toward the lower index.
   // ------------------------------------------------------------------
   always_comb begin
      w_cur_gate = r_gate[r_idx];
      w_cur_free = r_vfree[r_idx];
      w_cur_key  = r_key[r_idx];
      w_cur_age  = r_age[r_idx];

      w_c0_found = r_c0_found;
      w_c0_idx   = r_c0_idx;
      if (!r_c0_found && w_cur_gate && (w_cur_key == r_req_key)) begin
         w_c0_found = 1'b1;
         w_c0_idx   = r_idx;
      end

      w_c1_found = r_c1_found;
      w_c1_idx   = r_c1_idx;
      if (!r_c1_found && !w_cur_gate && w_cur_free) begin
         w_c1_found = 1'b1;
         w_c1_idx   = r_idx;
      end

      w_c2_found = r_c2_found;
      w_c2_idx   = r_c2_idx;
      w_c2_age   = r_c2_age;
      if (!w_cur_gate && (!r_c2_found || (w_cur_age > r_c2_age))) begin
         w_c2_found = 1'b1;
         w_c2_idx   = r_idx;
         w_c2_age   = w_cur_age;
      end

      w_c3_found = r_c3_found;
      w_c3_idx   = r_c3_idx;
      w_c3_age   = r_c3_age;
      if (w_cur_gate && (!r_c3_found || (w_cur_age > r_c3_age))) begin
         w_c3_found = 1'b1;
         w_c3_idx   = r_idx;
         w_c3_age   = w_cur_age;
      end
   end

   // ------------------------------------------------------------------
   // Note-on target selection. The assignments run lowest priority first,
   // so the highest-priority class that has a candidate wins.
   // ------------------------------------------------------------------
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      w_sel_cls   = C_STEAL;
      if (w_c3_found) begin
         w_sel_found = 1'b1;
         w_sel_idx   = w_c3_idx;
         w_sel_cls   = C_STEAL;
      end
      if (w_c2_found) begin
         w_sel_found = 1'b1;
         w_sel_idx   = w_c2_idx;
         w_sel_cls   = C_REL;
      end
      if (w_c1_found) begin
         w_sel_found = 1'b1;
         w_sel_idx   = w_c1_idx;
         w_sel_cls   = C_FREE;
      end
      if (w_c0_found) begin
         w_sel_found = 1'b1;
         w_sel_idx   = w_c0_idx;
         w_sel_cls   = C_RETRIG;
      end
   end

   // ------------------------------------------------------------------
   // Datapath. The commit happens on the edge that processes the last
   // voice, so that the gates, the count and the event fields change
   // together with the rising edge of evt_valid (the ISSUE cycle).
   // ------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         r_req_ready <= 1'b0;
         r_idx       <= '0;
         r_on        <= 1'b0;
         r_req_key   <= '0;
         r_req_vel   <= '0;
         r_vfree     <= '0;
         r_gate      <= '0;
         r_active    <= '0;
         for (int v = 0; v < VOICES; v++) begin
            r_key[v] <= L_NO_KEY;
            r_age[v] <= '0;
         end
         r_evt_valid <= 1'b0;
         r_evt_on    <= 1'b0;
         r_evt_voice <= '0;
         r_evt_key   <= '0;
         r_evt_vel   <= '0;
         r_evt_steal <= 1'b0;
         r_c0_found  <= 1'b0;
         r_c0_idx    <= '0;
         r_c1_found  <= 1'b0;
         r_c1_idx    <= '0;
         r_c2_found  <= 1'b0;
         r_c2_idx    <= '0;
         r_c2_age    <= '0;
         r_c3_found  <= 1'b0;
         r_c3_idx    <= '0;
         r_c3_age    <= '0;
      end else begin
         r_vfree     <= voice_free;
         r_evt_valid <= 1'b0;

         if (all_off) begin
            // Drop any request in flight. req_ready stays low for one
            // cycle and then comes back through the IDLE branch.
            r_req_ready <= 1'b0;
            r_idx       <= '0;
            r_gate      <= '0;
            r_active    <= '0;
            for (int v = 0; v < VOICES; v++) begin
               r_key[v] <= L_NO_KEY;
               r_age[v] <= '0;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_req_ready <= 1'b0;
                     r_idx       <= '0;
                     r_on        <= req_on & (req_vel != 8'd0);
                     r_req_key   <= req_key;
                     r_req_vel   <= req_vel;
                     r_c0_found  <= 1'b0;
                     r_c1_found  <= 1'b0;
                     r_c2_found  <= 1'b0;
                     r_c3_found  <= 1'b0;
                  end else begin
                     r_req_ready <= 1'b1;
                  end
               end

               S_SCAN: begin
                  if (!w_last) begin
                     r_idx      <= r_idx + V_WIDTH'(1);
                     r_c0_found <= w_c0_found;
                     r_c0_idx   <= w_c0_idx;
                     r_c1_found <= w_c1_found;
                     r_c1_idx   <= w_c1_idx;
                     r_c2_found <= w_c2_found;
                     r_c2_idx   <= w_c2_idx;
                     r_c2_age   <= w_c2_age;
                     r_c3_found <= w_c3_found;
                     r_c3_idx   <= w_c3_idx;
                     r_c3_age   <= w_c3_age;
                  end else if (r_on && w_sel_found) begin
                     r_gate[w_sel_idx] <= 1'b1;
                     r_key[w_sel_idx]  <= r_req_key;
                     for (int v = 0; v < VOICES; v++) begin
                        if (V_WIDTH'(v) == w_sel_idx) begin
                           r_age[v] <= '0;
                        end else if (r_age[v] != L_AGE_MX) begin
                           r_age[v] <= r_age[v] + 8'd1;
                        end
                     end
                     // Retrigger and steal reuse a voice that is already
                     // gated, so only a newly gated voice adds to the count.
                     if (((w_sel_cls == C_FREE) || (w_sel_cls == C_REL)) &&
                         (r_active != L_MAX)) begin
                        r_active <= r_active + AW'(1);
                     end
                     r_evt_valid <= 1'b1;
                     r_evt_on    <= 1'b1;
                     r_evt_voice <= w_sel_idx;
                     r_evt_key   <= r_req_key;
                     r_evt_vel   <= r_req_vel;
                     r_evt_steal <= (w_sel_cls == C_STEAL);
                  end else if (!r_on && w_c0_found) begin
                     // Release: the age is kept, so this voice competes
                     // as "oldest released" by the time it last started.
                     r_gate[w_c0_idx] <= 1'b0;
                     r_key[w_c0_idx]  <= L_NO_KEY;
                     if (r_active != '0) begin
                        r_active <= r_active - AW'(1);
                     end
                     r_evt_valid <= 1'b1;
                     r_evt_on    <= 1'b0;
                     r_evt_voice <= w_c0_idx;
                     r_evt_key   <= r_req_key;
                     r_evt_vel   <= r_req_vel;
                     r_evt_steal <= 1'b0;
                  end
                  // A note-off that matches no voice falls through here:
                  // ISSUE still takes one cycle, but nothing changes.
               end

               S_ISSUE: begin
                  r_req_ready <= 1'b1;
               end

               default: begin
                  r_req_ready <= 1'b0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign req_ready   = r_req_ready;
   assign keys_on     = r_gate;
   assign active_keys = r_active;
   assign evt_valid   = r_evt_valid;
   assign evt_on      = r_evt_on;
   assign evt_voice   = r_evt_voice;
   assign evt_key     = r_evt_key;
   assign evt_vel     = r_evt_vel;
   assign evt_steal   = r_evt_steal;

endmodule
